// File: rtl/fp_regfile_sb.sv
// Multi-port FP register file with per-register busy scoreboard for RAW/WAW hazard detection.
// Writes land 1 cycle after the edge; reads, busy and stall outputs are combinational (0 cycles).
// No backpressure on writeback; a WAW issue is refused via issue_stall_o and must be retried.
// Optional macro FP_RF_BYPASS_EN forwards same-cycle writeback data/busy onto matching read ports.
module fp_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_WR-1:0]        wb_en_i,
  input  logic [NUM_WR*IDX_W-1:0]  wb_index_i,
  input  logic [NUM_WR*XLEN-1:0]   wb_data_i,
  input  logic [NUM_RD*IDX_W-1:0]  rs_index_i,
  output logic [NUM_RD*XLEN-1:0]   rs_data_o,
  output logic [NUM_RD-1:0]        rs_busy_o,
  input  logic                     issue_en_i,
  input  logic [IDX_W-1:0]         issue_rd_i,
  output logic                     issue_stall_o,
  input  logic                     flush_i,
  output logic [CNT_W-1:0]         busy_cnt_o
);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_q;

  // WAW refusal looks at the busy state as it stands this cycle, before any clear or flush.
  assign issue_stall_o = issue_en_i & busy_q[issue_rd_i];
  assign busy_cnt_o    = cnt_q;

  // Next busy vector: wb clears, then issue set overrides, then flush overrides everything.
  always_comb begin
    busy_nxt = busy_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wb_en_i[p]) busy_nxt[wb_index_i[p*IDX_W +: IDX_W]] = 1'b0;
    end
    if (issue_en_i && !busy_q[issue_rd_i]) busy_nxt[issue_rd_i] = 1'b1;
    if (flush_i) busy_nxt = '0;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
    end
  end

  // Scoreboard state and its population count advance together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  // Register array; ports are visited in ascending order so the highest-numbered port wins a conflict.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wb_en_i[p]) mem[wb_index_i[p*IDX_W +: IDX_W]] <= wb_data_i[p*XLEN +: XLEN];
      end
    end
  end

  // Read ports: stored data and busy bit, optionally overridden by a same-cycle writeback.
  always_comb begin
    rs_data_o = '0;
    rs_busy_o = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rs_data_o[r*XLEN +: XLEN] = mem[rs_index_i[r*IDX_W +: IDX_W]];
      rs_busy_o[r]              = busy_q[rs_index_i[r*IDX_W +: IDX_W]];
`ifdef FP_RF_BYPASS_EN
      for (int p = 0; p < NUM_WR; p++) begin
        if (wb_en_i[p] && (wb_index_i[p*IDX_W +: IDX_W] == rs_index_i[r*IDX_W +: IDX_W])) begin
          rs_data_o[r*XLEN +: XLEN] = wb_data_i[p*XLEN +: XLEN];
          rs_busy_o[r]              = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_fp_regfile_sb.sv
// Directed bench for fp_regfile_sb with default parameters (32x32, 3 read, 2 write ports).
// Inputs change 1 time unit after a rising edge; outputs are sampled before the next edge.
// Expectations are hand-computed constants; the bypass case follows FP_RF_BYPASS_EN.
module tb_fp_regfile_sb;

  localparam int XLEN = 32;
  localparam int IDX_W = 5;
  localparam int NUM_RD = 3;
  localparam int NUM_WR = 2;
  localparam int CNT_W = 6;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_WR-1:0]       wb_en;
  logic [NUM_WR*IDX_W-1:0] wb_index;
  logic [NUM_WR*XLEN-1:0]  wb_data;
  logic [NUM_RD*IDX_W-1:0] rs_index;
  logic [NUM_RD*XLEN-1:0]  rs_data;
  logic [NUM_RD-1:0]       rs_busy;
  logic                    issue_en;
  logic [IDX_W-1:0]        issue_rd;
  logic                    issue_stall;
  logic                    flush;
  logic [CNT_W-1:0]        busy_cnt;

  int n_cmp = 0;
  int n_err = 0;

  fp_regfile_sb dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wb_en_i      (wb_en),
    .wb_index_i   (wb_index),
    .wb_data_i    (wb_data),
    .rs_index_i   (rs_index),
    .rs_data_o    (rs_data),
    .rs_busy_o    (rs_busy),
    .issue_en_i   (issue_en),
    .issue_rd_i   (issue_rd),
    .issue_stall_o(issue_stall),
    .flush_i      (flush),
    .busy_cnt_o   (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; issue_en = 1'b0; issue_rd = '0; wb_en = '0;
  endtask

  task automatic wr(input int p, input logic [IDX_W-1:0] idx, input logic [XLEN-1:0] d);
    wb_en[p] = 1'b1;
    wb_index[p*IDX_W +: IDX_W] = idx;
    wb_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int r, input logic [IDX_W-1:0] idx);
    rs_index[r*IDX_W +: IDX_W] = idx;
  endtask

  task automatic issue(input logic [IDX_W-1:0] idx);
    issue_en = 1'b1;
    issue_rd = idx;
  endtask

  function automatic logic [XLEN-1:0] rdat(input int r);
    return rs_data[r*XLEN +: XLEN];
  endfunction

  initial begin
    wb_index = '0; wb_data = '0; rs_index = '0;
    idle();
    rst = 1'b1;
    tick();
    idle();

    // Seed state: f5 written, f6 issued and written together (issue set outranks wb clear).
    wr(0, 5'd5, 32'h1111_1111);
    wr(1, 5'd6, 32'h2222_2222);
    issue(5'd6);
    tick();
    idle();
    rd(0, 5'd6); settle();
    chk("seed_f6_data", rdat(0), 32'h2222_2222);
    chk("seed_f6_busy", rs_busy[0], 1'b1);
    chk("seed_cnt", busy_cnt, 1);

    // Reset beats a concurrent write and issue.
    rst = 1'b1;
    wr(0, 5'd5, 32'hDEAD_BEEF);
    issue(5'd7);
    tick();
    idle();
    rd(0, 5'd5); rd(1, 5'd6); rd(2, 5'd7);
    issue(5'd6); settle();
    chk("rst_f5_data", rdat(0), 32'h0);
    chk("rst_f6_data", rdat(1), 32'h0);
    chk("rst_busy", rs_busy, 3'b000);
    chk("rst_cnt", busy_cnt, 0);
    chk("rst_stall", issue_stall, 1'b0);
    idle();

    // Both ports hit f5: port 1 wins; plain write leaves f5 not busy.
    wr(0, 5'd5, 32'h3F80_0000);
    wr(1, 5'd5, 32'h4000_0000);
    tick();
    idle();
    rd(0, 5'd5); settle();
    chk("conflict_f5", rdat(0), 32'h4000_0000);
    chk("conflict_busy", rs_busy[0], 1'b0);
    chk("conflict_cnt", busy_cnt, 0);

    // Issue f7, refuse a second issue, then write back.
    issue(5'd7); settle();
    chk("issue_f7_stall0", issue_stall, 1'b0);
    tick();
    idle();
    rd(0, 5'd7); settle();
    chk("issue_f7_busy", rs_busy[0], 1'b1);
    chk("issue_f7_cnt", busy_cnt, 1);
    issue(5'd7); settle();
    chk("waw_f7_stall", issue_stall, 1'b1);
    tick();
    idle(); settle();
    chk("waw_f7_cnt", busy_cnt, 1);
    wr(1, 5'd7, 32'h4049_0FDB);
    tick();
    idle(); settle();
    chk("wb_f7_busy", rs_busy[0], 1'b0);
    chk("wb_f7_cnt", busy_cnt, 0);
    chk("wb_f7_data", rdat(0), 32'h4049_0FDB);

    // Issue and writeback on busy f3 in one cycle: stall, busy clears, retry succeeds.
    issue(5'd3);
    tick();
    idle();
    rd(0, 5'd3); settle();
    chk("f3_busy", rs_busy[0], 1'b1);
    issue(5'd3);
    wr(0, 5'd3, 32'h3F00_0000); settle();
    chk("f3_same_stall", issue_stall, 1'b1);
    tick();
    idle(); settle();
    chk("f3_cleared", rs_busy[0], 1'b0);
    chk("f3_cleared_cnt", busy_cnt, 0);
    chk("f3_data", rdat(0), 32'h3F00_0000);
    issue(5'd3); settle();
    chk("f3_retry_stall", issue_stall, 1'b0);
    tick();
    idle(); settle();
    chk("f3_retry_busy", rs_busy[0], 1'b1);
    chk("f3_retry_cnt", busy_cnt, 1);

    // Busy f1, f2, f9 on top of f3, then flush with an issue to busy f1.
    issue(5'd1); tick();
    issue(5'd2); tick();
    issue(5'd9); tick();
    idle(); settle();
    chk("pre_flush_cnt", busy_cnt, 4);
    flush = 1'b1;
    issue(5'd1); settle();
    chk("flush_stall", issue_stall, 1'b1);
    tick();
    idle();
    rd(0, 5'd1); rd(1, 5'd2); rd(2, 5'd9); settle();
    chk("flush_busy", rs_busy, 3'b000);
    chk("flush_cnt", busy_cnt, 0);
    rd(0, 5'd5); rd(1, 5'd7); rd(2, 5'd3); settle();
    chk("flush_f5", rdat(0), 32'h4000_0000);
    chk("flush_f7", rdat(1), 32'h4049_0FDB);
    chk("flush_f3", rdat(2), 32'h3F00_0000);

    // Same-cycle read of a register being written back (f4 busy, old value 0).
    issue(5'd4); tick();
    idle();
    rd(0, 5'd4);
    wr(0, 5'd4, 32'hC000_0000); settle();
`ifdef FP_RF_BYPASS_EN
    chk("byp_f4_data", rdat(0), 32'hC000_0000);
    chk("byp_f4_busy", rs_busy[0], 1'b0);
`else
    chk("byp_f4_data", rdat(0), 32'h0);
    chk("byp_f4_busy", rs_busy[0], 1'b1);
`endif
    tick();
    idle(); settle();
    chk("post_f4_data", rdat(0), 32'hC000_0000);
    chk("post_f4_busy", rs_busy[0], 1'b0);
    chk("post_f4_cnt", busy_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_regfile_sb.md
Name: fp_regfile_sb

Overview:
- Parametrised multi-port floating-point register file with an integrated per-register busy scoreboard.
- Successor to the single-write / three-read FP register file: configurable width, depth, read-port count and write-port count.
- Tracks in-flight long-latency FP destinations so the issue stage can detect RAW and WAW hazards.
- Sits between the FP issue stage (reads, busy checks, destination reservation) and the FP writeback stage(s), e.g. FMA/DIV/SQRT completion buses.

Parameters:
- XLEN, 32, data width of each register in bits.
- DEPTH, 32, number of registers (power of two, >=2); IDX_W = $clog2(DEPTH).
- NUM_RD, 3, number of combinational read ports.
- NUM_WR, 2, number of writeback ports.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- wb_en_i  input  NUM_WR  per-port write enable.
- wb_index_i  input  NUM_WR*IDX_W  per-port destination index, port p at [p*IDX_W +: IDX_W].
- wb_data_i  input  NUM_WR*XLEN  per-port write data, port p at [p*XLEN +: XLEN].
- rs_index_i  input  NUM_RD*IDX_W  per-port read index.
- rs_data_o  output  NUM_RD*XLEN  per-port read data.
- rs_busy_o  output  NUM_RD  1 = register addressed by that read port has a pending write.
- issue_en_i  input  1  request to reserve issue_rd_i as an in-flight destination.
- issue_rd_i  input  IDX_W  destination index to reserve.
- issue_stall_o  output  1  1 = issue_rd_i is already busy (WAW); reservation refused.
- flush_i  input  1  pipeline flush; clears all busy bits, data untouched.
- busy_cnt_o  output  $clog2(DEPTH+1)  number of registers currently busy.

Behaviour:
- Reset (rst_i=1 at a clock edge): all registers <= 0; all busy bits <= 0; busy_cnt_o = 0. Reset has priority over every other input, including mid-operation writes and issues.
- Write: on each edge, for every p with wb_en_i[p]=1, reg[wb_index_i[p]] <= wb_data_i[p]. Write latency is 1 cycle.
- Same-index write conflict: when two or more ports target the same index in one cycle, the highest-numbered port wins. Lower ports are dropped silently.
- Read: rs_data_o / rs_busy_o are purely combinational from current state (0-cycle latency). Without the optional feature, a read of an index being written in the same cycle returns the old value.
- Scoreboard set: issue_en_i=1 and busy[issue_rd_i]=0 -> busy[issue_rd_i] <= 1 on the edge.
- Scoreboard refuse: issue_stall_o = issue_en_i & busy[issue_rd_i], combinational. A stalled request changes no state.
- Scoreboard clear: any wb_en_i[p]=1 clears busy[wb_index_i[p]] on the edge.
- Priority per index, highest first: rst_i > flush_i > issue set > wb clear.
  - Issue to index X in the same cycle as a writeback to X (X was busy): issue_stall_o=1 because X is busy this cycle; X's busy bit clears. Requester retries next cycle.
  - flush_i=1 with issue_en_i=1: every busy bit <= 0, including the requested one; issue_stall_o still reflects pre-flush state.
- Writes to a non-busy register are legal (e.g. FLW, FMV) and leave busy=0.
- busy_cnt_o: registered population count of busy bits, updated on the same edge as the busy bits. Never exceeds DEPTH.
- Index wrap: indices are exactly IDX_W bits; no out-of-range case exists.

Optional Feature:
- Macro: FP_RF_BYPASS_EN.
- Defined:
  - Each read port whose index matches an active write port in the current cycle returns wb_data_i of the highest-numbered matching port instead of stored data.
  - rs_busy_o for that port reads 0 that cycle.
  - The combinational path wb_* -> rs_* is allowed.
- Undefined: reads return stored data only; rs_busy_o reflects the stored busy bit. No combinational path from wb_* to rs_* exists.

Test Plan:
- Reset: drive writes, then rst_i=1 for 1 cycle -> all rs_data_o=0, rs_busy_o=0, busy_cnt_o=0, issue_stall_o=0.
- Port conflict: wb_en_i=2'b11, both index 5, data 0x3F800000 (port0) / 0x40000000 (port1) -> next cycle read of f5 = 0x40000000.
- Scoreboard: issue f7 -> rs_busy_o=1 for f7 and busy_cnt_o=1. Issue f7 again -> issue_stall_o=1 and busy_cnt_o stays 1. Writeback f7=0x40490FDB -> busy cleared, busy_cnt_o=0, data=0x40490FDB.
- Simultaneous issue and writeback on busy f3: issue_stall_o=1 that cycle -> next cycle busy[f3]=0. Retry issue -> busy[f3]=1.
- Flush: busy f1, f2, f9, then flush_i=1 -> all busy 0, busy_cnt_o=0, stored data unchanged.
- Bypass (FP_RF_BYPASS_EN defined): write f4=0xC0000000 while reading f4 in the same cycle -> rs_data_o=0xC0000000 that cycle. Macro undefined -> old value returned that cycle, new value the next cycle.
